// File: rtl/alsu_stim_gen_if.sv
// ALSU drive/observe bus between the stimulus generator and the ALSU under test.
interface alsu_stim_gen_if;
  logic       alsu_rst;
  logic       cin;
  logic       serial_in;
  logic       red_op_A;
  logic       red_op_B;
  logic       bypass_A;
  logic       bypass_B;
  logic       direction;
  logic [2:0] A;
  logic [2:0] B;
  logic [2:0] opcode;
  logic [5:0] out_in;

  modport master (
    output alsu_rst, cin, serial_in, red_op_A, red_op_B,
           bypass_A, bypass_B, direction, A, B, opcode,
    input  out_in
  );

  modport slave (
    input  alsu_rst, cin, serial_in, red_op_A, red_op_B,
           bypass_A, bypass_B, direction, A, B, opcode,
    output out_in
  );
endinterface

// File: rtl/alsu_stim_gen.sv
// ALSU stimulus generator: phased LFSR-driven drives with a MISR signature over out_in.
module alsu_stim_gen #(
  parameter logic [15:0] SEED  = 16'hACE1,
  parameter int unsigned N_RST = 1,
  parameter int unsigned N_P1  = 5,
  parameter int unsigned N_P2  = 15
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   start,
  alsu_stim_gen_if.master        bus,
  output logic                   busy,
  output logic                   done,
  output logic [15:0]            signature
);

  localparam int unsigned CNT_W = 8;
  localparam logic [15:0] LFSR_TAPS = 16'hB400;
  // A zero seed would lock the LFSR, so it is replaced by 1.
  localparam logic [15:0] SEED_EFF  = (SEED == 16'h0000) ? 16'h0001 : SEED;

  typedef enum logic [2:0] {
    S_IDLE, S_INIT, S_PH1, S_PH2, S_DRAIN, S_DONE
  } state_t;

  state_t             state, state_nxt;
  logic [CNT_W-1:0]   cnt, cnt_nxt;
  logic [15:0]        lfsr, lfsr_adv, sig_nxt;
  logic [2:0]         op_sel;
  logic               accept;
  logic               lfsr_run, misr_run, busy_nxt;

  // Next state and phase-length counter.
  always_comb begin
    state_nxt = state;
    cnt_nxt   = (cnt == '0) ? cnt : cnt - CNT_W'(1);
    case (state)
      S_IDLE:  if (start) begin
                 state_nxt = S_INIT;
                 cnt_nxt   = CNT_W'(N_RST - 1);
               end
      S_INIT:  if (cnt == '0) begin
                 state_nxt = S_PH1;
                 cnt_nxt   = CNT_W'(N_P1 - 1);
               end
      S_PH1:   if (cnt == '0) begin
                 state_nxt = S_PH2;
                 cnt_nxt   = CNT_W'(N_P2 - 1);
               end
      S_PH2:   if (cnt == '0) begin
                 state_nxt = S_DRAIN;
                 cnt_nxt   = CNT_W'(1);
               end
      S_DRAIN: if (cnt == '0) begin
                 state_nxt = S_DONE;
                 cnt_nxt   = '0;
               end
      S_DONE:  state_nxt = S_IDLE;
      default: begin
                 state_nxt = S_IDLE;
                 cnt_nxt   = '0;
               end
    endcase
  end

  always_comb begin
    accept   = (state == S_IDLE) && start;
    lfsr_run = (state_nxt == S_PH1) || (state_nxt == S_PH2);
    misr_run = (state == S_PH1) || (state == S_PH2) || (state == S_DRAIN);
    busy_nxt = (state_nxt == S_INIT) || (state_nxt == S_PH1) ||
               (state_nxt == S_PH2)  || (state_nxt == S_DRAIN);
    lfsr_adv = (lfsr >> 1) ^ (lfsr[0] ? LFSR_TAPS : 16'h0000);
    sig_nxt  = {signature[14:0], signature[15] ^ signature[13] ^ signature[12] ^ signature[10]}
               ^ {10'b0, bus.out_in};
    // Fold 6 and 7 back onto 0 and 1 so the opcode stays legal.
    op_sel   = (lfsr[2:0] >= 3'd6) ? (lfsr[2:0] - 3'd6) : lfsr[2:0];
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= S_IDLE;
      cnt           <= '0;
      busy          <= 1'b0;
      done          <= 1'b0;
      signature     <= '0;
      lfsr          <= SEED_EFF;
      bus.alsu_rst  <= 1'b1;
      bus.cin       <= 1'b1;
      bus.serial_in <= 1'b1;
      bus.red_op_A  <= 1'b0;
      bus.red_op_B  <= 1'b0;
      bus.bypass_A  <= 1'b0;
      bus.bypass_B  <= 1'b0;
      bus.direction <= 1'b1;
      bus.A         <= 3'd5;
      bus.B         <= 3'd1;
      bus.opcode    <= 3'd2;
    end else begin
      state <= state_nxt;
      cnt   <= cnt_nxt;
      busy  <= busy_nxt;
      done  <= (state_nxt == S_DONE);

      if (accept) begin
        lfsr      <= SEED_EFF;
        signature <= '0;
      end else begin
        if (lfsr_run) lfsr      <= lfsr_adv;
        if (misr_run) signature <= sig_nxt;
      end

      // Drives follow the state being entered; DRAIN and DONE hold.
      case (state_nxt)
        S_IDLE, S_INIT: begin
          bus.alsu_rst  <= 1'b1;
          bus.bypass_A  <= 1'b0;
          bus.bypass_B  <= 1'b0;
          bus.direction <= 1'b1;
          bus.A         <= 3'd5;
          bus.B         <= 3'd1;
          bus.opcode    <= 3'd2;
        end
        S_PH1: begin
          bus.alsu_rst                   <= 1'b0;
          {bus.A, bus.B, bus.direction}  <= lfsr[15:9];
          bus.opcode                     <= op_sel;
        end
        S_PH2: begin
          {bus.bypass_A, bus.bypass_B}   <= lfsr[10:9];
          bus.opcode                     <= op_sel;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alsu_stim_gen.sv
// Bench for alsu_stim_gen: table of runs checked cycle by cycle against a phase-schedule model.
module tb_alsu_stim_gen;

  localparam logic [16:0] DEF_DRV = {1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0,
                                     3'd5, 3'd1, 1'b1, 3'd2};

  logic        clk = 1'b0;
  logic        rst;
  logic        start0, start1;
  logic [5:0]  out_val;
  logic        busy0, done0, busy1, done1;
  logic [15:0] sig0, sig1;
  int          checks = 0;
  int          errors = 0;

  always #5 clk = ~clk;

  alsu_stim_gen_if bus0 ();
  alsu_stim_gen_if bus1 ();
  assign bus0.out_in = out_val;
  assign bus1.out_in = out_val;

  alsu_stim_gen #(.SEED(16'hACE1), .N_RST(1), .N_P1(5), .N_P2(15)) u_dut0 (
    .clk(clk), .rst(rst), .start(start0), .bus(bus0),
    .busy(busy0), .done(done0), .signature(sig0)
  );

  alsu_stim_gen #(.SEED(16'h0000), .N_RST(1), .N_P1(3), .N_P2(2)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .bus(bus1),
    .busy(busy1), .done(done1), .signature(sig1)
  );

  typedef struct packed {
    logic [16:0] drv;   // alsu_rst,cin,serial_in,red_A,red_B,byp_A,byp_B,A,B,dir,opcode
    logic        busy;
    logic        done;
    logic [15:0] sig;
  } obs_t;

  typedef struct {
    int          idx;
    int          pat;        // 0: out_in constant, 1: out_in random
    logic [5:0]  cval;
    bit          hold;       // keep start high through the run
    int          exp_busy;
    logic [2:0]  a1, b1;
    logic        dir1;
    logic [2:0]  op1;
    bit          sig_known;
    logic [15:0] exp_sig;
  } vec_t;

  vec_t tbl[6];

  function automatic obs_t get_obs(input int idx);
    obs_t o;
    if (idx == 0)
      o = {bus0.alsu_rst, bus0.cin, bus0.serial_in, bus0.red_op_A, bus0.red_op_B,
           bus0.bypass_A, bus0.bypass_B, bus0.A, bus0.B, bus0.direction, bus0.opcode,
           busy0, done0, sig0};
    else
      o = {bus1.alsu_rst, bus1.cin, bus1.serial_in, bus1.red_op_A, bus1.red_op_B,
           bus1.bypass_A, bus1.bypass_B, bus1.A, bus1.B, bus1.direction, bus1.opcode,
           busy1, done1, sig1};
    return o;
  endfunction

  function automatic logic [15:0] lfsr_step(input logic [15:0] l);
    return l[0] ? ((l >> 1) ^ 16'hB400) : (l >> 1);
  endfunction

  function automatic logic [2:0] fold_op(input logic [2:0] x);
    return 3'(int'(x) % 6);
  endfunction

  function automatic logic [15:0] misr_step(input logic [15:0] s, input logic [5:0] d);
    return ((s << 1) | 16'(^(s & 16'hB400))) ^ 16'(d);
  endfunction

  // Expected drives during busy cycle k (DRAIN keeps the last PH2 values).
  function automatic logic [16:0] exp_drv(input logic [15:0] lq[$], input int nrst,
                                          input int np1, input int np2, input int k);
    logic [15:0] la, lb;
    int j;
    if (k < nrst) return DEF_DRV;
    j = k - nrst;
    if (j > np1 + np2 - 1) j = np1 + np2 - 1;
    la = lq[(j < np1) ? j : np1 - 1];
    lb = lq[j];
    return {1'b0, 1'b1, 1'b1, 1'b0, 1'b0, (j < np1) ? 2'b00 : lb[10:9],
            la[15:9], fold_op(lb[2:0])};
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic set_start(input int idx, input logic v);
    if (idx == 0) start0 = v;
    else          start1 = v;
  endtask

  task automatic run_check(input vec_t v);
    logic [15:0] lq[$];
    logic [15:0] l, s;
    int nrst, np1, np2, total, busy_cnt;
    bit timed_out;
    obs_t o;
    nrst = 1;
    np1  = (v.idx == 0) ? 5 : 3;
    np2  = (v.idx == 0) ? 15 : 2;
    l    = (v.idx == 0) ? 16'hACE1 : 16'h0001;
    total = nrst + np1 + np2 + 2;
    for (int j = 0; j < np1 + np2; j++) begin
      lq.push_back(l);
      l = lfsr_step(l);
    end
    s = '0;
    busy_cnt  = 0;
    timed_out = 1'b1;

    @(negedge clk);
    set_start(v.idx, 1'b1);
    out_val = 6'($urandom);
    for (int k = 0; k < 400; k++) begin
      @(negedge clk);
      o = get_obs(v.idx);
      if (!o.busy) begin
        timed_out = 1'b0;
        break;
      end
      busy_cnt++;
      if (!v.hold) set_start(v.idx, 1'b0);
      if (k < total) begin
        chk($sformatf("drv[%0d] k=%0d", v.idx, k), 32'(o.drv), 32'(exp_drv(lq, nrst, np1, np2, k)));
        chk($sformatf("done_low[%0d] k=%0d", v.idx, k), 32'(o.done), 32'd0);
      end
      if (k == nrst)
        chk($sformatf("ph1_first[%0d]", v.idx), 32'(o.drv[9:0]), 32'({v.a1, v.b1, v.dir1, v.op1}));
      if (v.idx == 0 && k == nrst + 1)
        chk("ph1_second", 32'(o.drv[9:0]), 32'({3'd7, 3'd0, 1'b1, 3'd0}));
      if (k >= nrst && k < nrst + np1 + np2)
        chk($sformatf("op_range[%0d] k=%0d", v.idx, k), 32'(o.drv[2:0] < 3'd6), 32'd1);
      out_val = (v.pat == 1) ? 6'($urandom) : v.cval;
      if (k >= nrst) s = misr_step(s, out_val);
    end
    if (timed_out) chk($sformatf("busy_timeout[%0d]", v.idx), 32'd1, 32'd0);

    // DONE cycle
    chk($sformatf("busy_len[%0d]", v.idx), 32'(busy_cnt), 32'(v.exp_busy));
    chk($sformatf("done_pulse[%0d]", v.idx), 32'(o.done), 32'd1);
    chk($sformatf("sig_model[%0d]", v.idx), 32'(o.sig), 32'(s));
    if (v.sig_known) chk($sformatf("sig_const[%0d]", v.idx), 32'(o.sig), 32'(v.exp_sig));
    chk($sformatf("drv_done[%0d]", v.idx), 32'(o.drv), 32'(exp_drv(lq, nrst, np1, np2, total - 1)));

    // Back in IDLE
    @(negedge clk);
    o = get_obs(v.idx);
    chk($sformatf("done_once[%0d]", v.idx), 32'(o.done), 32'd0);
    chk($sformatf("idle_busy[%0d]", v.idx), 32'(o.busy), 32'd0);
    chk($sformatf("sig_hold[%0d]", v.idx), 32'(o.sig), 32'(s));
    chk($sformatf("drv_idle[%0d]", v.idx), 32'(o.drv), 32'(DEF_DRV));

    if (v.hold) begin
      @(negedge clk);
      o = get_obs(v.idx);
      chk($sformatf("restart[%0d]", v.idx), 32'(o.busy), 32'd1);
      set_start(v.idx, 1'b0);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
    end
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    obs_t o;
    tbl[0] = '{0, 0, 6'h00, 1'b0, 23, 3'd5, 3'd3, 1'b0, 3'd1, 1'b1, 16'h0000};
    tbl[1] = '{0, 0, 6'h3F, 1'b0, 23, 3'd5, 3'd3, 1'b0, 3'd1, 1'b0, 16'h0000};
    tbl[2] = '{0, 1, 6'h00, 1'b0, 23, 3'd5, 3'd3, 1'b0, 3'd1, 1'b0, 16'h0000};
    tbl[3] = '{0, 1, 6'h00, 1'b1, 23, 3'd5, 3'd3, 1'b0, 3'd1, 1'b0, 16'h0000};
    tbl[4] = '{1, 1, 6'h00, 1'b0, 8,  3'd0, 3'd0, 1'b0, 3'd1, 1'b0, 16'h0000};
    tbl[5] = '{1, 0, 6'h00, 1'b0, 8,  3'd0, 3'd0, 1'b0, 3'd1, 1'b1, 16'h0000};

    rst = 1'b0; start0 = 1'b0; start1 = 1'b0; out_val = '0;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 2; i++) begin
      o = get_obs(i);
      chk($sformatf("reset_drv[%0d]", i), 32'(o.drv), 32'(DEF_DRV));
      chk($sformatf("reset_flags[%0d]", i), 32'({o.busy, o.done, o.sig}), 32'd0);
    end
    rst = 1'b1;
    @(negedge clk);

    for (int i = 0; i < 6; i++) run_check(tbl[i]);

    // Reset during PH2 aborts the run at once, without a done pulse.
    @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    repeat (8) @(negedge clk);
    chk("mid_busy", 32'(busy0), 32'd1);
    #2 rst = 1'b0;
    #1;
    o = get_obs(0);
    chk("abort_drv", 32'(o.drv), 32'(DEF_DRV));
    chk("abort_flags", 32'({o.busy, o.done, o.sig}), 32'd0);
    repeat (2) begin
      @(negedge clk);
      chk("abort_no_done", 32'(done0), 32'd0);
    end
    rst = 1'b1;
    repeat (3) begin
      @(negedge clk);
      chk("post_abort_idle", 32'({busy0, done0}), 32'd0);
    end
    run_check(tbl[2]);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
